// File: rtl/rf_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_arbiter_pkg
//  Description : Shared widths, commit-source encodings, defaults and the
//                buffered divider-result entry type for the register-file
//                writeback arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    // commit_src encodings
    localparam logic WB_SRC_PIPE = 1'b0;
    localparam logic WB_SRC_DIV  = 1'b1;

    // Defaults for the top-level parameters
    localparam int DEFAULT_STARVE_LIMIT  = 4;
    localparam int DEFAULT_DIV_BUF_DEPTH = 2;

    // One buffered divider completion
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // x0 is hard-wired zero: writes to it are no-ops and it is never busy
    function automatic logic is_x0(input logic [REG_ADDR_W-1:0] r);
        return (r == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wb_arbiter_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_result_fifo
//  Description : Parameterised synchronous FIFO holding divider results until
//                the register-file write port has a free slot. The head entry
//                is presented combinationally from storage (first-word
//                fall-through), so a pushed entry is visible at the head the
//                cycle after the push.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                i_push         - write i_push_data (ignored when full)
//                i_push_data    - entry to enqueue
//                i_pop          - retire the head entry (ignored when empty)
//                o_full/o_empty - occupancy flags
//                o_head         - current head entry (valid when !o_empty)
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_result_fifo #(
    parameter int DEPTH = 2,   // power of 2, minimum 2
    parameter int WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    localparam logic [c_ptr_w-1:0] c_last_ptr = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    // Pointers alone cannot tell full from empty; the count register does.
    assign o_full    = (r_count == c_depth);
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];

    function automatic logic [c_ptr_w-1:0] next_ptr(input logic [c_ptr_w-1:0] p);
        return (p == c_last_ptr) ? '0 : p + 1'b1;
    endfunction

    // Storage needs no reset: occupancy is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rf_wb_arbiter
//  Description : Owns the single register-file write port and shares it
//                between the in-order pipeline writeback and the divider
//                completion path. Divider results are buffered and drained
//                into free slots; a starvation counter forces a pipeline hold
//                when the head result has been denied STARVE_LIMIT times.
//                A 32-entry busy scoreboard tracks in-flight divides for the
//                hazard unit and flags pipeline writes to busy registers.
//  Ports       : clk, rst                 - clock, sync active-high reset
//                pipe_we/rd/data, pipe_hold - pipeline writeback + stall
//                div_issue, div_issue_rd  - divide entering the divider
//                div_valid/rd/data, div_ready - divider result handshake
//                q_rs1/rs2/rd, q_*_busy   - scoreboard queries
//                rf_we/rd/data            - register-file write port
//                commit_src               - 0 pipeline, 1 divider
//                waw_err                  - sticky write-to-busy flag
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DIV_BUF_DEPTH = DEFAULT_DIV_BUF_DEPTH,  // power of 2, min 2
    parameter int STARVE_LIMIT  = DEFAULT_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,
    // pipeline writeback
    input  logic                  pipe_we,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_data,
    output logic                  pipe_hold,
    // divider
    input  logic                  div_issue,
    input  logic [REG_ADDR_W-1:0] div_issue_rd,
    input  logic                  div_valid,
    input  logic [REG_ADDR_W-1:0] div_rd,
    input  logic [XLEN-1:0]       div_data,
    output logic                  div_ready,
    // scoreboard queries
    input  logic [REG_ADDR_W-1:0] q_rs1,
    input  logic [REG_ADDR_W-1:0] q_rs2,
    input  logic [REG_ADDR_W-1:0] q_rd,
    output logic                  q_rs1_busy,
    output logic                  q_rs2_busy,
    output logic                  q_rd_busy,
    // register file write port
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_data,
    output logic                  commit_src,
    output logic                  waw_err
);

    localparam int c_nregs    = 1 << REG_ADDR_W;
    localparam int c_starve_w = $clog2(STARVE_LIMIT + 2);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);

    // ------------------------------------------------------------------
    // Divider result buffer
    // ------------------------------------------------------------------
    wb_entry_t w_push_entry;
    wb_entry_t w_head;
    logic      w_full;
    logic      w_empty;
    logic      w_push;
    logic      w_pop;

    assign w_push_entry = '{rd: div_rd, data: div_data};

    // A pop in the same cycle does not open a slot for the divider: the
    // ready depends only on the registered occupancy, which keeps the
    // divider handshake free of a path through the grant logic.
    assign div_ready = !rst && !w_full;
    assign w_push    = div_valid && div_ready;

    wb_result_fifo #(
        .DEPTH (DIV_BUF_DEPTH),
        .WIDTH ($bits(wb_entry_t))
    ) u_div_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_entry),
        .i_pop       (w_pop),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_head      (w_head)
    );

    // ------------------------------------------------------------------
    // Grant logic
    // ------------------------------------------------------------------
    logic [c_starve_w-1:0] r_starve;
    logic                  w_pipe_writes;
    logic                  w_starved;
    logic                  w_div_grant;
    logic                  w_contend;
    logic                  w_pipe_commit;
    logic                  w_div_commit;

    // A pipeline write to x0 leaves the slot free for the divider.
    assign w_pipe_writes = pipe_we && !is_x0(pipe_rd);
    assign w_starved     = !w_empty && (r_starve == c_starve_max);

    always_comb begin
        w_div_grant = 1'b0;
        w_contend   = 1'b0;
        if (!rst && !w_empty) begin
            if (!w_pipe_writes || w_starved) begin
                w_div_grant = 1'b1;
            end else begin
                w_contend = 1'b1;
            end
        end
    end

    assign w_pop         = w_div_grant;
    // A head entry for x0 retires through a divider grant with no write.
    assign w_div_commit  = w_div_grant && !is_x0(w_head.rd);
    assign w_pipe_commit = !rst && !w_div_grant && w_pipe_writes;

    always_comb begin
        rf_we      = 1'b0;
        rf_rd      = '0;
        rf_data    = '0;
        commit_src = WB_SRC_PIPE;
        pipe_hold  = 1'b0;
        if (!rst) begin
            if (w_div_grant) begin
                rf_we      = w_div_commit;
                rf_rd      = w_head.rd;
                rf_data    = w_head.data;
                commit_src = WB_SRC_DIV;
            end else begin
                rf_we      = w_pipe_commit;
                rf_rd      = pipe_rd;
                rf_data    = pipe_data;
            end
            pipe_hold = w_starved;
        end
    end

    // Counts consecutive pipeline wins over a waiting head entry; a
    // contended win is only possible below the limit, so it cannot overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_empty || w_div_grant) begin
            r_starve <= '0;
        end else if (w_contend) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Busy scoreboard
    // ------------------------------------------------------------------
    logic [c_nregs-1:0] r_busy;
    logic [c_nregs-1:0] w_busy_next;

    // Clear first, then set, so an issue to the register being retired in
    // the same cycle leaves it busy for the new divide.
    always_comb begin
        w_busy_next = r_busy;
        if (w_div_commit) begin
            w_busy_next[w_head.rd] = 1'b0;
        end
        if (div_issue && !is_x0(div_issue_rd)) begin
            w_busy_next[div_issue_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_next;
        end
    end

    assign q_rs1_busy = !rst && !is_x0(q_rs1) && r_busy[q_rs1];
    assign q_rs2_busy = !rst && !is_x0(q_rs2) && r_busy[q_rs2];
    assign q_rd_busy  = !rst && !is_x0(q_rd)  && r_busy[q_rd];

    // ------------------------------------------------------------------
    // Sticky WAW error: pipeline overwrote a register a divide still owns
    // ------------------------------------------------------------------
    logic r_waw_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_waw_err <= 1'b0;
        end else if (w_pipe_commit && r_busy[pipe_rd]) begin
            r_waw_err <= 1'b1;
        end
    end

    assign waw_err = r_waw_err && !rst;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rf_wb_arbiter
//  Description : Self-checking bench for rf_wb_arbiter. A queue-based model
//                of the arbiter is compared against the DUT every cycle, and
//                directed scenarios pin hand-computed values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_hold;
    logic        div_issue;
    logic [4:0]  div_issue_rd;
    logic        div_valid;
    logic [4:0]  div_rd;
    logic [31:0] div_data;
    logic        div_ready;
    logic [4:0]  q_rs1, q_rs2, q_rd;
    logic        q_rs1_busy, q_rs2_busy, q_rd_busy;
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [31:0] rf_data;
    logic        commit_src;
    logic        waw_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(
        .DIV_BUF_DEPTH (DEPTH),
        .STARVE_LIMIT  (LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_we      (pipe_we),
        .pipe_rd      (pipe_rd),
        .pipe_data    (pipe_data),
        .pipe_hold    (pipe_hold),
        .div_issue    (div_issue),
        .div_issue_rd (div_issue_rd),
        .div_valid    (div_valid),
        .div_rd       (div_rd),
        .div_data     (div_data),
        .div_ready    (div_ready),
        .q_rs1        (q_rs1),
        .q_rs2        (q_rs2),
        .q_rd         (q_rd),
        .q_rs1_busy   (q_rs1_busy),
        .q_rs2_busy   (q_rs2_busy),
        .q_rd_busy    (q_rd_busy),
        .rf_we        (rf_we),
        .rf_rd        (rf_rd),
        .rf_data      (rf_data),
        .commit_src   (commit_src),
        .waw_err      (waw_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: queue of pending results, busy array, denial count
    // ------------------------------------------------------------------
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t      m_q[$];
    bit [31:0] m_busy;
    int        m_starve;
    bit        m_waw;

    always @(negedge clk) begin : model
        ent_t        h;
        int          n;
        bit          pw, dw, e_we, e_hold, e_rdy, e_src;
        logic [4:0]  e_rd;
        logic [31:0] e_data;

        n  = m_q.size();
        pw = pipe_we && (pipe_rd != 5'd0);
        e_rd = '0;
        e_data = '0;
        if (rst) begin
            dw = 0; e_we = 0; e_hold = 0; e_rdy = 0; e_src = 0;
        end else begin
            e_rdy  = (n < DEPTH);
            dw     = (n > 0) && (!pw || m_starve == LIMIT);
            e_hold = (n > 0) && (m_starve == LIMIT);
            e_src  = dw;
            if (dw) begin
                e_we = (m_q[0].rd != 5'd0); e_rd = m_q[0].rd; e_data = m_q[0].data;
            end else begin
                e_we = pw; e_rd = pipe_rd; e_data = pipe_data;
            end
        end

        chk("m_rf_we", {31'd0, rf_we}, {31'd0, e_we});
        chk("m_pipe_hold", {31'd0, pipe_hold}, {31'd0, e_hold});
        chk("m_div_ready", {31'd0, div_ready}, {31'd0, e_rdy});
        chk("m_commit_src", {31'd0, commit_src}, {31'd0, e_src});
        if (e_we) begin
            chk("m_rf_rd", {27'd0, rf_rd}, {27'd0, e_rd});
            chk("m_rf_data", rf_data, e_data);
        end
        chk("m_q_rs1_busy", {31'd0, q_rs1_busy}, {31'd0, !rst && q_rs1 != 0 && m_busy[q_rs1]});
        chk("m_q_rs2_busy", {31'd0, q_rs2_busy}, {31'd0, !rst && q_rs2 != 0 && m_busy[q_rs2]});
        chk("m_q_rd_busy",  {31'd0, q_rd_busy},  {31'd0, !rst && q_rd  != 0 && m_busy[q_rd]});
        if (!rst) chk("m_waw_err", {31'd0, waw_err}, {31'd0, m_waw});

        if (rst) begin
            m_q.delete(); m_busy = '0; m_starve = 0; m_waw = 0;
        end else begin
            if (!dw && pw && m_busy[pipe_rd]) m_waw = 1;
            if (dw) begin
                h = m_q.pop_front();
                if (h.rd != 5'd0) m_busy[h.rd] = 0;
                m_starve = 0;
            end else if (n == 0) begin
                m_starve = 0;
            end else begin
                m_starve++;
            end
            if (div_issue && div_issue_rd != 5'd0) m_busy[div_issue_rd] = 1;
            if (div_valid && e_rdy) m_q.push_back('{div_rd, div_data});
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    task automatic idle();
        pipe_we = 0; pipe_rd = 0; pipe_data = 0;
        div_issue = 0; div_issue_rd = 0;
        div_valid = 0; div_rd = 0; div_data = 0;
        q_rs1 = 0; q_rs2 = 0; q_rd = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pipe(input logic [4:0] rd, input logic [31:0] d);
        pipe_we = 1; pipe_rd = rd; pipe_data = d;
    endtask

    task automatic divres(input logic [4:0] rd, input logic [31:0] d);
        div_valid = 1; div_rd = rd; div_data = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; idle();
        pipe(5'd3, 32'h1); divres(5'd4, 32'h2);
        #1;
        chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
        chk("rst_div_ready", {31'd0, div_ready}, 32'd0);
        chk("rst_pipe_hold", {31'd0, pipe_hold}, 32'd0);
        cyc(); cyc();
        rst = 0; idle();
        #1;
        chk("post_rst_ready", {31'd0, div_ready}, 32'd1);
        chk("post_rst_waw", {31'd0, waw_err}, 32'd0);
        cyc();

        // Single result, idle pipeline
        div_issue = 1; div_issue_rd = 5'd5; cyc();
        idle(); q_rs1 = 5'd5; #1;
        chk("t1_busy_set", {31'd0, q_rs1_busy}, 32'd1);
        chk("t1_x0_busy", {31'd0, q_rs2_busy}, 32'd0);
        divres(5'd5, 32'h7); #1;
        chk("t1_no_bypass", {31'd0, rf_we}, 32'd0);
        cyc();
        idle(); q_rs1 = 5'd5; #1;
        chk("t1_we", {31'd0, rf_we}, 32'd1);
        chk("t1_rd", {27'd0, rf_rd}, 32'd5);
        chk("t1_data", rf_data, 32'h7);
        chk("t1_src", {31'd0, commit_src}, 32'd1);
        chk("t1_busy_still", {31'd0, q_rs1_busy}, 32'd1);
        cyc();
        chk("t1_busy_clr", {31'd0, q_rs1_busy}, 32'd0);
        cyc();

        // Contention: pipeline wins LIMIT times, then hold
        pipe(5'd3, 32'h33); divres(5'd6, 32'h66); #1;
        chk("t2_first", {27'd0, rf_rd}, 32'd3);
        cyc();
        div_valid = 0;
        for (int k = 0; k < LIMIT; k++) begin
            #1;
            chk("t2_pipe_win_rd", {27'd0, rf_rd}, 32'd3);
            chk("t2_no_hold", {31'd0, pipe_hold}, 32'd0);
            cyc();
        end
        #1;
        chk("t2_hold", {31'd0, pipe_hold}, 32'd1);
        chk("t2_div_rd", {27'd0, rf_rd}, 32'd6);
        chk("t2_div_data", rf_data, 32'h66);
        cyc();
        chk("t2_replay_rd", {27'd0, rf_rd}, 32'd3);
        chk("t2_replay_src", {31'd0, commit_src}, 32'd0);
        chk("t2_replay_hold", {31'd0, pipe_hold}, 32'd0);
        cyc();
        idle(); cyc();

        // Full FIFO under continuous pipeline writes
        pipe(5'd3, 32'h44);
        divres(5'd10, 32'hA); cyc();
        divres(5'd11, 32'hB); #1;
        chk("t3_ready_one", {31'd0, div_ready}, 32'd1);
        cyc();
        divres(5'd12, 32'hC);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t3_full", {31'd0, div_ready}, 32'd0);
            cyc();
        end
        #1;
        chk("t3_hold", {31'd0, pipe_hold}, 32'd1);
        chk("t3_pop_rd", {27'd0, rf_rd}, 32'd10);
        chk("t3_ready_on_pop", {31'd0, div_ready}, 32'd0);
        cyc();
        chk("t3_ready_after", {31'd0, div_ready}, 32'd1);
        chk("t3_pipe_rd", {27'd0, rf_rd}, 32'd3);
        cyc();
        idle(); #1;
        chk("t3_drain_11", {27'd0, rf_rd}, 32'd11);
        cyc();
        chk("t3_drain_12", {27'd0, rf_rd}, 32'd12);
        chk("t3_drain_data", rf_data, 32'hC);
        cyc();
        chk("t3_empty", {31'd0, rf_we}, 32'd0);
        cyc();

        // x0 handling
        pipe(5'd0, 32'hDEAD); divres(5'd13, 32'hD); #1;
        chk("t4_x0_pipe", {31'd0, rf_we}, 32'd0);
        cyc();
        div_valid = 0; #1;
        chk("t4_slot_div", {27'd0, rf_rd}, 32'd13);
        chk("t4_slot_src", {31'd0, commit_src}, 32'd1);
        cyc();
        idle(); divres(5'd0, 32'hEE); cyc();
        idle(); #1;
        chk("t4_x0_drop", {31'd0, rf_we}, 32'd0);
        cyc();
        divres(5'd14, 32'h14); cyc();
        idle(); #1;
        chk("t4_after_drop", {27'd0, rf_rd}, 32'd14);
        chk("t4_after_drop_we", {31'd0, rf_we}, 32'd1);
        cyc();

        // Simultaneous set/clear, then WAW
        div_issue = 1; div_issue_rd = 5'd9; cyc();
        idle(); divres(5'd9, 32'h99); cyc();
        idle(); div_issue = 1; div_issue_rd = 5'd9; #1;
        chk("t5_commit9", {27'd0, rf_rd}, 32'd9);
        cyc();
        idle(); q_rd = 5'd9; #1;
        chk("t5_set_wins", {31'd0, q_rd_busy}, 32'd1);
        pipe(5'd9, 32'h1); #1;
        chk("t5_waw_before", {31'd0, waw_err}, 32'd0);
        cyc();
        idle(); #1;
        chk("t5_waw_set", {31'd0, waw_err}, 32'd1);
        cyc(); cyc();
        chk("t5_waw_sticky", {31'd0, waw_err}, 32'd1);

        // Reset mid-operation
        pipe(5'd3, 32'h55); div_issue = 1; div_issue_rd = 5'd20; divres(5'd20, 32'h20); cyc();
        div_issue_rd = 5'd21; divres(5'd21, 32'h21); cyc();
        idle(); pipe(5'd3, 32'h56); q_rs1 = 5'd20; q_rs2 = 5'd21; #1;
        chk("t6_full", {31'd0, div_ready}, 32'd0);
        chk("t6_busy20", {31'd0, q_rs1_busy}, 32'd1);
        chk("t6_busy21", {31'd0, q_rs2_busy}, 32'd1);
        cyc();
        idle(); rst = 1; #1;
        chk("t6_rst_we", {31'd0, rf_we}, 32'd0);
        cyc();
        rst = 0; q_rs1 = 5'd20; q_rs2 = 5'd21; q_rd = 5'd9; #1;
        chk("t6_ready", {31'd0, div_ready}, 32'd1);
        chk("t6_no_commit", {31'd0, rf_we}, 32'd0);
        chk("t6_clr20", {31'd0, q_rs1_busy}, 32'd0);
        chk("t6_clr21", {31'd0, q_rs2_busy}, 32'd0);
        chk("t6_clr9", {31'd0, q_rd_busy}, 32'd0);
        chk("t6_waw_clr", {31'd0, waw_err}, 32'd0);
        cyc();
        chk("t6_still_idle", {31'd0, rf_we}, 32'd0);
        cyc(); cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
